// File: rtl/player_sequencer_if.sv
// rtl/player_sequencer_if.sv - control pulses in, beat index and play status out
interface player_sequencer_if;
   logic       play;
   logic       pause;
   logic       stop;
   logic       loop_en;
   logic [1:0] tempo;
   logic [7:0] ibeat;
   logic       mute;
   logic       playing;
   logic       done;

   modport master (
      output play, pause, stop, loop_en, tempo,
      input  ibeat, mute, playing, done
   );

   modport slave (
      input  play, pause, stop, loop_en, tempo,
      output ibeat, mute, playing, done
   );
endinterface

// File: rtl/player_sequencer.sv
// rtl/player_sequencer.sv - beat sequencer FSM for song playback
// Optional note gap muting at the end of each beat: define NOTE_GAP_EN.
module player_sequencer #(
   parameter int CLK_HZ   = 100_000_000,
   parameter int BEAT_LEN = 128,
   parameter int GAP_DIV  = 8
) (
   input  logic              clk,
   input  logic              reset,
   player_sequencer_if.slave bus
);
   localparam int P0 = CLK_HZ / 4;
   localparam int P1 = CLK_HZ / 8;
   localparam int P2 = CLK_HZ / 12;
   localparam int P3 = CLK_HZ / 16;
   localparam int CNT_W = (P0 > 1) ? $clog2(P0 + 1) : 1;
   localparam logic [7:0] LAST_BEAT = 8'(BEAT_LEN - 1);

   if (BEAT_LEN < 2 || BEAT_LEN > 256 || GAP_DIV < 1 || P3 < 1) begin : g_bad_cfg
      $error("player_sequencer: unsupported parameter set");
   end

   typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n, per_m1;
   logic [7:0]       ibeat, ibeat_n;
   logic [1:0]       tsel, tsel_n;
   logic             done_n, mute_n;
   logic             mute_q, playing_q, done_q;

   // Period of the beat in progress comes from the tempo latched at its start.
   always_comb begin
      case (tsel)
         2'd0:    per_m1 = CNT_W'(P0 - 1);
         2'd1:    per_m1 = CNT_W'(P1 - 1);
         2'd2:    per_m1 = CNT_W'(P2 - 1);
         default: per_m1 = CNT_W'(P3 - 1);
      endcase
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      ibeat_n = ibeat;
      tsel_n  = tsel;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.play) begin
               state_n = PLAY;
               cnt_n   = '0;
               ibeat_n = 8'd0;
               tsel_n  = bus.tempo;
            end
         end
         PLAY: begin
            if (bus.stop) begin
               state_n = IDLE;
               cnt_n   = '0;
               ibeat_n = 8'd0;
            end else if (bus.pause) begin
               state_n = PAUSE;
            end else if (cnt == per_m1) begin
               cnt_n  = '0;
               tsel_n = bus.tempo;
               if (ibeat == LAST_BEAT) begin
                  ibeat_n = 8'd0;
                  if (!bus.loop_en) begin
                     state_n = IDLE;
                     done_n  = 1'b1;
                  end
               end else begin
                  ibeat_n = ibeat + 8'd1;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         PAUSE: begin
            if (bus.stop) begin
               state_n = IDLE;
               cnt_n   = '0;
               ibeat_n = 8'd0;
            end else if (bus.play) begin
               state_n = PLAY;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
            ibeat_n = 8'd0;
         end
      endcase
   end

`ifdef NOTE_GAP_EN
   localparam int G0 = P0 - P0 / GAP_DIV;
   localparam int G1 = P1 - P1 / GAP_DIV;
   localparam int G2 = P2 - P2 / GAP_DIV;
   localparam int G3 = P3 - P3 / GAP_DIV;
   logic [CNT_W-1:0] gap_start;

   always_comb begin
      case (tsel_n)
         2'd0:    gap_start = CNT_W'(G0);
         2'd1:    gap_start = CNT_W'(G1);
         2'd2:    gap_start = CNT_W'(G2);
         default: gap_start = CNT_W'(G3);
      endcase
   end

   assign mute_n = (state_n != PLAY) || (cnt_n >= gap_start);
`else
   assign mute_n = (state_n != PLAY);
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         ibeat     <= 8'd0;
         tsel      <= 2'd0;
         mute_q    <= 1'b1;
         playing_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         ibeat     <= ibeat_n;
         tsel      <= tsel_n;
         mute_q    <= mute_n;
         playing_q <= (state_n == PLAY);
         done_q    <= done_n;
      end
   end

   assign bus.ibeat   = ibeat;
   assign bus.mute    = mute_q;
   assign bus.playing = playing_q;
   assign bus.done    = done_q;
endmodule

// File: tb/tb_player_sequencer.sv
// tb/tb_player_sequencer.sv - directed self-checking bench for player_sequencer
module tb_player_sequencer;
   localparam int CLK_HZ   = 160;
   localparam int BEAT_LEN = 4;
   localparam int GAP_DIV  = 8;
`ifdef NOTE_GAP_EN
   localparam bit GAP_ON = 1'b1;
`else
   localparam bit GAP_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   player_sequencer_if bus();

   player_sequencer #(
      .CLK_HZ  (CLK_HZ),
      .BEAT_LEN(BEAT_LEN),
      .GAP_DIV (GAP_DIV)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_play();
      bus.play = 1'b1;
      tick();
      bus.play = 1'b0;
   endtask

   task automatic pulse_stop();
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.play = 1'b1;
      tick();
      tick();
      bus.play = 1'b0;
      checks++; if (bus.ibeat !== 8'd0) begin failures++; $display("FAIL reset_ibeat got=%0d exp=0", bus.ibeat); end
      checks++; if (bus.mute !== 1'b1) begin failures++; $display("FAIL reset_mute got=%b exp=1", bus.mute); end
      checks++; if (bus.playing !== 1'b0) begin failures++; $display("FAIL reset_playing got=%b exp=0", bus.playing); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_play_once();
      logic [7:0] e_beat;
      logic       e_done, e_play, e_mute;
      bus.tempo = 2'd1;
      bus.loop_en = 1'b0;
      pulse_play();
      checks++; if (bus.playing !== 1'b1) begin failures++; $display("FAIL once_start_playing got=%b exp=1", bus.playing); end
      checks++; if (bus.ibeat !== 8'd0) begin failures++; $display("FAIL once_start_ibeat got=%0d exp=0", bus.ibeat); end
      for (int k = 1; k <= 81; k++) begin
         tick();
         e_beat = (k < 80) ? 8'(k / 20) : 8'd0;
         e_done = (k == 80);
         e_play = (k < 80);
         e_mute = (k >= 80) ? 1'b1 : (GAP_ON && (k % 20) >= 18);
         checks++; if (bus.ibeat !== e_beat) begin failures++; $display("FAIL once_ibeat k=%0d got=%0d exp=%0d", k, bus.ibeat, e_beat); end
         checks++; if (bus.done !== e_done) begin failures++; $display("FAIL once_done k=%0d got=%b exp=%b", k, bus.done, e_done); end
         checks++; if (bus.playing !== e_play) begin failures++; $display("FAIL once_playing k=%0d got=%b exp=%b", k, bus.playing, e_play); end
         checks++; if (bus.mute !== e_mute) begin failures++; $display("FAIL once_mute k=%0d got=%b exp=%b", k, bus.mute, e_mute); end
      end
   endtask

   task automatic test_loop();
      logic [7:0] e_beat;
      bus.tempo = 2'd3;
      bus.loop_en = 1'b1;
      pulse_play();
      for (int k = 1; k <= 60; k++) begin
         tick();
         e_beat = 8'((k / 10) % 4);
         checks++; if (bus.ibeat !== e_beat) begin failures++; $display("FAIL loop_ibeat k=%0d got=%0d exp=%0d", k, bus.ibeat, e_beat); end
         checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL loop_done k=%0d got=%b exp=0", k, bus.done); end
      end
      pulse_stop();
      checks++; if (bus.playing !== 1'b0) begin failures++; $display("FAIL loop_stop_playing got=%b exp=0", bus.playing); end
      checks++; if (bus.ibeat !== 8'd0) begin failures++; $display("FAIL loop_stop_ibeat got=%0d exp=0", bus.ibeat); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL loop_stop_done got=%b exp=0", bus.done); end
   endtask

   task automatic test_pause();
      bus.tempo = 2'd3;
      bus.loop_en = 1'b1;
      pulse_play();
      repeat (7) tick();
      bus.pause = 1'b1;
      tick();
      bus.pause = 1'b0;
      checks++; if (bus.playing !== 1'b0) begin failures++; $display("FAIL pause_playing got=%b exp=0", bus.playing); end
      for (int i = 1; i <= 50; i++) begin
         if (i == 25) bus.pause = 1'b1;
         tick();
         bus.pause = 1'b0;
         checks++; if (bus.ibeat !== 8'd0) begin failures++; $display("FAIL pause_ibeat i=%0d got=%0d exp=0", i, bus.ibeat); end
         checks++; if (bus.mute !== 1'b1) begin failures++; $display("FAIL pause_mute i=%0d got=%b exp=1", i, bus.mute); end
      end
      pulse_play();
      checks++; if (bus.playing !== 1'b1) begin failures++; $display("FAIL resume_playing got=%b exp=1", bus.playing); end
      for (int k = 1; k <= 3; k++) begin
         if (k == 1) bus.play = 1'b1;
         tick();
         bus.play = 1'b0;
         checks++; if (bus.ibeat !== ((k == 3) ? 8'd1 : 8'd0)) begin failures++; $display("FAIL resume_ibeat k=%0d got=%0d exp=%0d", k, bus.ibeat, (k == 3) ? 1 : 0); end
      end
      pulse_stop();
   endtask

   task automatic test_stop_play_same();
      bus.tempo = 2'd3;
      bus.loop_en = 1'b0;
      pulse_play();
      repeat (4) tick();
      bus.stop = 1'b1;
      bus.play = 1'b1;
      tick();
      bus.stop = 1'b0;
      bus.play = 1'b0;
      checks++; if (bus.playing !== 1'b0) begin failures++; $display("FAIL sp_playing got=%b exp=0", bus.playing); end
      checks++; if (bus.ibeat !== 8'd0) begin failures++; $display("FAIL sp_ibeat got=%0d exp=0", bus.ibeat); end
      checks++; if (bus.mute !== 1'b1) begin failures++; $display("FAIL sp_mute got=%b exp=1", bus.mute); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL sp_done got=%b exp=0", bus.done); end
      pulse_play();
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k >= 9) begin
            checks++; if (bus.ibeat !== ((k == 10) ? 8'd1 : 8'd0)) begin failures++; $display("FAIL sp_restart_ibeat k=%0d got=%0d", k, bus.ibeat); end
         end
      end
      pulse_stop();
   endtask

   task automatic test_stop_at_end();
      bus.tempo = 2'd3;
      bus.loop_en = 1'b0;
      pulse_play();
      repeat (39) tick();
      checks++; if (bus.ibeat !== 8'd3) begin failures++; $display("FAIL end_pre_ibeat got=%0d exp=3", bus.ibeat); end
      pulse_stop();
      checks++; if (bus.playing !== 1'b0) begin failures++; $display("FAIL end_stop_playing got=%b exp=0", bus.playing); end
      checks++; if (bus.ibeat !== 8'd0) begin failures++; $display("FAIL end_stop_ibeat got=%0d exp=0", bus.ibeat); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL end_stop_done got=%b exp=0", bus.done); end
      tick();
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL end_stop_done_late got=%b exp=0", bus.done); end
   endtask

   task automatic test_tempo_change();
      bus.tempo = 2'd0;
      bus.loop_en = 1'b0;
      pulse_play();
      for (int k = 1; k <= 100; k++) begin
         tick();
         if (k == 45) bus.tempo = 2'd3;
         if (k == 79 || k == 80 || k == 89 || k == 90) begin
            checks++;
            if (bus.ibeat !== ((k < 80) ? 8'd1 : (k < 90) ? 8'd2 : 8'd3)) begin
               failures++; $display("FAIL tempo_ibeat k=%0d got=%0d", k, bus.ibeat);
            end
         end
      end
      checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL tempo_done got=%b exp=1", bus.done); end
      tick();
   endtask

   task automatic test_gap_and_reset();
      logic e_mute;
      bus.tempo = 2'd0;
      bus.loop_en = 1'b1;
      pulse_play();
      for (int k = 1; k <= 45; k++) begin
         tick();
         e_mute = GAP_ON && ((k % 40) >= 35);
         checks++; if (bus.mute !== e_mute) begin failures++; $display("FAIL gap_mute k=%0d got=%b exp=%b", k, bus.mute, e_mute); end
      end
      checks++; if (bus.ibeat !== 8'd1) begin failures++; $display("FAIL rst_pre_ibeat got=%0d exp=1", bus.ibeat); end
      reset = 1'b0;
      bus.play = 1'b1;
      tick();
      checks++; if (bus.ibeat !== 8'd0) begin failures++; $display("FAIL rst_mid_ibeat got=%0d exp=0", bus.ibeat); end
      checks++; if (bus.playing !== 1'b0) begin failures++; $display("FAIL rst_mid_playing got=%b exp=0", bus.playing); end
      checks++; if (bus.mute !== 1'b1) begin failures++; $display("FAIL rst_mid_mute got=%b exp=1", bus.mute); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_mid_done got=%b exp=0", bus.done); end
      bus.play = 1'b0;
      reset = 1'b1;
      repeat (30) tick();
      checks++; if (bus.playing !== 1'b0) begin failures++; $display("FAIL rst_idle_playing got=%b exp=0", bus.playing); end
      checks++; if (bus.ibeat !== 8'd0) begin failures++; $display("FAIL rst_idle_ibeat got=%0d exp=0", bus.ibeat); end
   endtask

   initial begin
      reset = 1'b0;
      bus.play = 1'b0;
      bus.pause = 1'b0;
      bus.stop = 1'b0;
      bus.loop_en = 1'b0;
      bus.tempo = 2'd0;
      test_reset();
      test_play_once();
      test_loop();
      test_pause();
      test_stop_play_same();
      test_stop_at_end();
      test_tempo_change();
      test_gap_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/player_sequencer.md
PLAYER_SEQUENCER -- requirements
Module: player_sequencer

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, meaning system clock frequency in Hz.
REQ-002 Parameter BEAT_LEN, default 128, meaning number of beats in the song (2..256).
REQ-003 Parameter GAP_DIV, default 8, meaning the note gap lasts 1/GAP_DIV of the beat period (used only with NOTE_GAP_EN).
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 play  input  1  single-cycle start/resume pulse, already debounced.
REQ-007 pause  input  1  single-cycle pause pulse.
REQ-008 stop  input  1  single-cycle stop pulse.
REQ-009 loop_en  input  1  level; 1 = wrap to beat 0 after the last beat.
REQ-010 tempo  input  2  tempo select: 0=4, 1=8, 2=12, 3=16 beats/s.
REQ-011 ibeat  output  8  current beat index to the Music lookup.
REQ-012 mute  output  1  1 = tone generator output silenced.
REQ-013 playing  output  1  1 while in PLAY.
REQ-014 done  output  1  single-cycle pulse when the song ends without loop.

Function
REQ-015 The FSM SHALL have states IDLE, PLAY and PAUSE.
REQ-016 Beat period SHALL be P = CLK_HZ/4, /8, /12 or /16 clock cycles for tempo 0..3, truncated integer constants computed at elaboration.
REQ-017 A beat counter SHALL count 0..P-1 only in PLAY; in IDLE and PAUSE it holds.
REQ-018 Tempo SHALL be latched at each beat start (IDLE->PLAY and every ibeat advance); a tempo change mid-beat takes effect at the next beat.
REQ-019 When the counter reaches P-1 in PLAY, it SHALL go to 0 next cycle and ibeat SHALL advance by 1 in the same cycle.
REQ-020 At ibeat = BEAT_LEN-1 and counter = P-1 with loop_en=1, ibeat SHALL wrap to 0 and PLAY continues.
REQ-021 At the same point with loop_en=0, the FSM SHALL go to IDLE, ibeat SHALL go to 0, and done SHALL pulse for exactly one cycle.
REQ-022 In IDLE, play SHALL enter PLAY next cycle with ibeat=0, counter=0 and playing=1.
REQ-023 In PLAY, pause SHALL enter PAUSE; counter and ibeat are retained.
REQ-024 In PAUSE, play SHALL return to PLAY, resuming from the retained counter value.
REQ-025 stop in PLAY or PAUSE SHALL enter IDLE next cycle with ibeat=0 and counter=0; done SHALL NOT pulse.
REQ-026 Priority for simultaneous pulses SHALL be stop > pause > play.
REQ-027 A stop in the same cycle as the end-of-song condition SHALL win: IDLE, no done pulse.
REQ-028 Redundant pulses SHALL be ignored: play in PLAY, pause in IDLE or PAUSE, stop in IDLE.
REQ-029 mute SHALL be 1 in IDLE and PAUSE.
REQ-030 All outputs SHALL be registered; state changes SHALL be visible one cycle after the triggering input.

Reset
REQ-031 With reset=0 at a clock edge, the block SHALL set state=IDLE, ibeat=0, counter=0, mute=1, playing=0 and done=0, regardless of the other inputs.
REQ-032 Reset asserted mid-song SHALL discard position; after release the block waits in IDLE for play.

Configuration
REQ-033 Macro NOTE_GAP_EN defined: in PLAY, mute SHALL be 1 when counter >= P - P/GAP_DIV, and 0 otherwise.
REQ-034 Macro NOTE_GAP_EN undefined: mute SHALL be 0 throughout PLAY, and the GAP_DIV comparison logic SHALL be absent.

Verification (CLK_HZ=160, BEAT_LEN=4, so P=40/20/13/10)
REQ-035 Stimulus: tempo=1, loop_en=0, play pulse. Required response: ibeat steps 0,1,2,3 every 20 cycles; done pulses once 80 cycles after PLAY entry; ibeat=0, playing=0.
REQ-036 Stimulus: loop_en=1, tempo=3, play. Required response: ibeat sequence 0,1,2,3,0,1 at 10-cycle spacing; done never asserts.
REQ-037 Stimulus: pause at counter=7, wait 50 cycles, then play. Required response: ibeat unchanged during the pause, mute=1, and the next advance comes 3 cycles after resume (tempo 3).
REQ-038 Stimulus: stop and play in the same cycle during PLAY; separately, stop exactly at end-of-song. Required response: IDLE, ibeat=0, no done pulse.
REQ-039 Stimulus: tempo changed from 0 to 3 at counter=5 of beat 1. Required response: beat 1 lasts 40 cycles, beat 2 lasts 10 cycles.
REQ-040 Stimulus: NOTE_GAP_EN defined, tempo=0. Required response: mute=1 for counter 35..39 of each beat and 0 otherwise; reset=0 mid-beat forces all outputs to reset values on the next edge.
